// File: rtl/pe_group_feeder_pkg.sv
// pe_group_feeder_pkg
//   Shared definitions for the PE-group feeder: top FSM state encoding,
//   memory read latency and per-channel word totals for one tile.
package pe_group_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } feederState_e;

  // Scratchpad read data is valid exactly this many cycles after RdEn.
  // The channel pipeline tracks a single in-flight bit, which only holds
  // for a latency of one.
  localparam int RdLatency = 1;

  // W words per tile: the same W_PEGroupSize weights in every block.
  function automatic int wTotal(input int blockCount, input int wSize);
    return blockCount * wSize;
  endfunction

  // I words per tile: full window in block 0, then an O-sized increment
  // in each later block.
  function automatic int iTotal(input int blockCount, input int iSize, input int oSize);
    return iSize + (blockCount - 1) * oSize;
  endfunction

  // O words per tile: partial sums are only sent in block 0.
  function automatic int oTotal(input int oSize);
    return oSize;
  endfunction

endpackage

// File: rtl/pe_group_feeder_if.sv
// pe_group_feeder_if
//   Bundles the tile-control, scratchpad read and PE-group stream signals
//   of the feeder.
//   master: feeder side (drives Busy/Done, read strobes/addresses, streams)
//   slave : environment side (tile controller, scratchpads, PE group)
//
// Stream handshake: a word transfers on a clock edge where DataOutValid and
// DataOutRdy are both high. Once Valid is raised it stays high, with
// DataOut unchanged, until that transfer happens. Rdy may be high before
// Valid, and Valid never depends combinationally on Rdy.
interface pe_group_feeder_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 10
);
  logic                 Start;
  logic [AddrWidth-1:0] W_Base, I_Base, O_Base;
  logic                 Busy;
  logic                 Done;

  logic                 W_RdEn, I_RdEn, O_RdEn;
  logic [AddrWidth-1:0] W_RdAddr, I_RdAddr, O_RdAddr;
  logic [DataWidth-1:0] W_RdData, I_RdData, O_RdData;

  logic                 W_DataOutValid, I_DataOutValid, O_DataOutValid;
  logic                 W_DataOutRdy, I_DataOutRdy, O_DataOutRdy;
  logic [DataWidth-1:0] W_DataOut, I_DataOut, O_DataOut;

  modport master (
    input  Start, W_Base, I_Base, O_Base,
    input  W_RdData, I_RdData, O_RdData,
    input  W_DataOutRdy, I_DataOutRdy, O_DataOutRdy,
    output Busy, Done,
    output W_RdEn, I_RdEn, O_RdEn,
    output W_RdAddr, I_RdAddr, O_RdAddr,
    output W_DataOutValid, I_DataOutValid, O_DataOutValid,
    output W_DataOut, I_DataOut, O_DataOut
  );

  modport slave (
    output Start, W_Base, I_Base, O_Base,
    output W_RdData, I_RdData, O_RdData,
    output W_DataOutRdy, I_DataOutRdy, O_DataOutRdy,
    input  Busy, Done,
    input  W_RdEn, I_RdEn, O_RdEn,
    input  W_RdAddr, I_RdAddr, O_RdAddr,
    input  W_DataOutValid, I_DataOutValid, O_DataOutValid,
    input  W_DataOut, I_DataOut, O_DataOut
  );
endinterface

// File: rtl/pe_feed_channel.sv
// pe_feed_channel
//   One stream channel of the feeder: issues Total scratchpad reads per
//   tile, buffers returning words in a 2-entry FIFO and presents them on a
//   valid/rdy stream.
//   Ports:
//     clk, aclr      clock, synchronous active-high reset
//     launch         accepted tile start; issues word 0 at baseIn this cycle
//     run            tile in progress (top FSM in RUN)
//     baseIn         tile base address, latched on launch
//     rdEn/rdAddr    scratchpad read strobe and address
//     rdData         read data, valid one cycle after rdEn
//     dataOutValid/dataOutRdy/dataOut  output stream
//     finishing      accept count equals Total after this cycle's edge
//   RepeatMode != 0 makes the address offset (index mod Period), otherwise
//   the offset is the linear word index.
module pe_feed_channel #(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 10,
  parameter int Total      = 16,
  parameter int RepeatMode = 0,
  parameter int Period     = 4
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 launch,
  input  logic                 run,
  input  logic [AddrWidth-1:0] baseIn,
  output logic                 rdEn,
  output logic [AddrWidth-1:0] rdAddr,
  input  logic [DataWidth-1:0] rdData,
  output logic                 dataOutValid,
  input  logic                 dataOutRdy,
  output logic [DataWidth-1:0] dataOut,
  output logic                 finishing
);

  localparam int CountWidth = $clog2(Total + 1);

  logic [CountWidth-1:0] issueCnt, acceptCnt, issueIdx;
  logic [CountWidth:0]   acceptNext;
  logic [AddrWidth-1:0]  baseReg, addrBase, offset;
  logic                  inFlight;
  logic [DataWidth-1:0]  fifoMem [2];
  logic                  wrPtr, rdPtr;
  logic [1:0]            fifoCnt;
  logic                  push, pop, canIssue;

  assign push         = inFlight;
  assign pop          = dataOutValid & dataOutRdy;
  assign dataOutValid = (fifoCnt != 2'd0);
  assign dataOut      = fifoMem[rdPtr];

  // Occupancy after this edge is fifoCnt + arriving word - departing word.
  // Issuing only while that is below 2 leaves a slot for the new read's
  // data, so nothing is dropped under backpressure, yet a pop in the same
  // cycle still frees a slot and keeps one word per cycle flowing.
  assign canIssue = run && (issueCnt < CountWidth'(Total)) &&
                    (({1'b0, fifoCnt} + {2'b00, inFlight} - {2'b00, pop}) < 3'd2);

  // The launch cycle issues word 0 straight from the incoming base so the
  // first word is on the stream two cycles after Start.
  assign rdEn     = launch | canIssue;
  assign issueIdx = launch ? '0 : issueCnt;
  assign addrBase = launch ? baseIn : baseReg;

  always_comb begin
    offset = AddrWidth'(issueIdx);
    if (RepeatMode != 0) begin
      offset = AddrWidth'(issueIdx % CountWidth'(Period));
    end
  end

  // Address arithmetic wraps modulo 2^AddrWidth.
  assign rdAddr = addrBase + offset;

  assign acceptNext = {1'b0, acceptCnt} + (CountWidth + 1)'(pop);
  assign finishing  = (acceptNext == (CountWidth + 1)'(Total));

  always_ff @(posedge clk) begin
    if (aclr) begin
      issueCnt   <= '0;
      acceptCnt  <= '0;
      baseReg    <= '0;
      inFlight   <= 1'b0;
      wrPtr      <= 1'b0;
      rdPtr      <= 1'b0;
      fifoCnt    <= 2'd0;
      fifoMem[0] <= '0;
      fifoMem[1] <= '0;
    end else begin
      inFlight <= rdEn;
      if (launch) begin
        baseReg   <= baseIn;
        issueCnt  <= CountWidth'(1);
        acceptCnt <= '0;
      end else begin
        if (canIssue) issueCnt  <= issueCnt + 1'b1;
        if (pop)      acceptCnt <= acceptCnt + 1'b1;
      end
      if (push) begin
        fifoMem[wrPtr] <= rdData;
        wrPtr          <= ~wrPtr;
      end
      if (pop) rdPtr <= ~rdPtr;
      fifoCnt <= fifoCnt + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/pe_group_feeder.sv
// pe_group_feeder
//   Tile sequencer feeding the W, I and O streams of one PE group from
//   three scratchpad read ports. Each tile sends W_PEGroupSize weights per
//   block (repeated every block), the full I window in block 0 plus an
//   O-sized increment in every later block, and the O partial sums once.
//   Ports:
//     clk, aclr   clock, synchronous active-high reset
//     bus         pe_group_feeder_if.master: Start/bases/Busy/Done, the
//                 three read ports and the three output streams
//     stateDbg    current top FSM state
//     blockDbg    W block currently being accepted (wraps to 0 at tile end)
module pe_group_feeder
  import pe_group_feeder_pkg::*;
#(
  parameter int DataWidth       = 32,
  parameter int AddrWidth       = 10,
  parameter int W_PEGroupSize   = 4,
  parameter int O_PEGroupSize   = 4,
  parameter int I_PEGroupSize   = 7,
  parameter int BlockCount      = 4,
  parameter int BlockCountWidth = 2
) (
  input  logic                       clk,
  input  logic                       aclr,
  pe_group_feeder_if.master          bus,
  output feederState_e               stateDbg,
  output logic [BlockCountWidth-1:0] blockDbg
);

  localparam int WordIdxWidth = (W_PEGroupSize > 1) ? $clog2(W_PEGroupSize) : 1;

  feederState_e state, stateNext;
  logic         launch, run;
  logic         wFin, iFin, oFin;
  logic         wHs;
  logic [WordIdxWidth-1:0]    wordInBlk;
  logic [BlockCountWidth-1:0] blockCnt;

  // Start is only honoured in IDLE; in RUN and FIN it is ignored.
  assign launch = bus.Start && (state == IDLE);
  assign run    = (state == RUN);

  always_ff @(posedge clk) begin
    if (aclr) state <= IDLE;
    else      state <= stateNext;
  end

  // Channel finish flags already include this cycle's handshake, so FIN
  // (and Done) lands the cycle after the last channel's final transfer.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (bus.Start) stateNext = RUN;
      RUN:     if (wFin && iFin && oFin) stateNext = FIN;
      FIN:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign bus.Busy = (state != IDLE);
  assign bus.Done = (state == FIN);
  assign stateDbg = state;

  // Block tracking follows the W stream: every W_PEGroupSize accepted
  // weights close a block, and BlockCount blocks bring it back to 0.
  assign wHs = bus.W_DataOutValid & bus.W_DataOutRdy;

  always_ff @(posedge clk) begin
    if (aclr || launch) begin
      wordInBlk <= '0;
      blockCnt  <= '0;
    end else if (wHs) begin
      if (wordInBlk == WordIdxWidth'(W_PEGroupSize - 1)) begin
        wordInBlk <= '0;
        blockCnt  <= blockCnt + 1'b1;
      end else begin
        wordInBlk <= wordInBlk + 1'b1;
      end
    end
  end

  assign blockDbg = blockCnt;

  pe_feed_channel #(
    .DataWidth (DataWidth),
    .AddrWidth (AddrWidth),
    .Total     (wTotal(BlockCount, W_PEGroupSize)),
    .RepeatMode(1),
    .Period    (W_PEGroupSize)
  ) wChan (
    .clk         (clk),
    .aclr        (aclr),
    .launch      (launch),
    .run         (run),
    .baseIn      (bus.W_Base),
    .rdEn        (bus.W_RdEn),
    .rdAddr      (bus.W_RdAddr),
    .rdData      (bus.W_RdData),
    .dataOutValid(bus.W_DataOutValid),
    .dataOutRdy  (bus.W_DataOutRdy),
    .dataOut     (bus.W_DataOut),
    .finishing   (wFin)
  );

  pe_feed_channel #(
    .DataWidth (DataWidth),
    .AddrWidth (AddrWidth),
    .Total     (iTotal(BlockCount, I_PEGroupSize, O_PEGroupSize)),
    .RepeatMode(0),
    .Period    (1)
  ) iChan (
    .clk         (clk),
    .aclr        (aclr),
    .launch      (launch),
    .run         (run),
    .baseIn      (bus.I_Base),
    .rdEn        (bus.I_RdEn),
    .rdAddr      (bus.I_RdAddr),
    .rdData      (bus.I_RdData),
    .dataOutValid(bus.I_DataOutValid),
    .dataOutRdy  (bus.I_DataOutRdy),
    .dataOut     (bus.I_DataOut),
    .finishing   (iFin)
  );

  pe_feed_channel #(
    .DataWidth (DataWidth),
    .AddrWidth (AddrWidth),
    .Total     (oTotal(O_PEGroupSize)),
    .RepeatMode(0),
    .Period    (1)
  ) oChan (
    .clk         (clk),
    .aclr        (aclr),
    .launch      (launch),
    .run         (run),
    .baseIn      (bus.O_Base),
    .rdEn        (bus.O_RdEn),
    .rdAddr      (bus.O_RdAddr),
    .rdData      (bus.O_RdData),
    .dataOutValid(bus.O_DataOutValid),
    .dataOutRdy  (bus.O_DataOutRdy),
    .dataOut     (bus.O_DataOut),
    .finishing   (oFin)
  );

endmodule

// File: tb/tb_pe_group_feeder.sv
// tb_pe_group_feeder
//   Directed bench for pe_group_feeder: scratchpad models with one-cycle
//   read latency, a stream monitor, expected queues built from the
//   IEEE-754 word values, and a final summary line.
module tb_pe_group_feeder;
  import pe_group_feeder_pkg::*;

  localparam int DW = 32;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic aclr;
  always #5 clk = ~clk;

  pe_group_feeder_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();
  feederState_e stateDbg;
  logic [1:0]   blockDbg;

  pe_group_feeder #(
    .DataWidth(DW), .AddrWidth(AW), .W_PEGroupSize(4), .O_PEGroupSize(4),
    .I_PEGroupSize(7), .BlockCount(4), .BlockCountWidth(2)
  ) dut (
    .clk     (clk),
    .aclr    (aclr),
    .bus     (bus),
    .stateDbg(stateDbg),
    .blockDbg(blockDbg)
  );

  // ---------------- scratchpads ----------------
  logic [DW-1:0] wMem [1024];
  logic [DW-1:0] iMem [1024];
  logic [DW-1:0] oMem [1024];

  always @(posedge clk) begin
    if (bus.W_RdEn) bus.W_RdData <= wMem[bus.W_RdAddr];
    if (bus.I_RdEn) bus.I_RdData <= iMem[bus.I_RdAddr];
    if (bus.O_RdEn) bus.O_RdData <= oMem[bus.O_RdAddr];
  end

  // ---------------- bookkeeping ----------------
  int nAssert = 0;
  int nFail   = 0;
  int cyc     = 0;
  int doneCnt, busyCyc, firstValidCyc, lastIHsCyc, doneCyc, startCyc;
  logic [DW-1:0] wObs[$], iObs[$], oObs[$];
  logic [AW-1:0] iAddrObs[$];
  logic [DW-1:0] expQ[$];
  logic          wHeld = 1'b0, iHeld = 1'b0;
  logic [DW-1:0] wHeldVal, iHeldVal;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Small positive integer to IEEE-754 single precision bits.
  function automatic logic [31:0] f2b(input int n);
    int e;
    logic [31:0] m;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    m = 32'(n) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  // ---------------- monitor (samples on falling edge) ----------------
  always @(negedge clk) begin
    if (aclr) begin
      wHeld = 1'b0;
      iHeld = 1'b0;
    end else begin
      if (wHeld) begin
        check("wStallValid", 32'(bus.W_DataOutValid), 32'd1);
        check("wStallData", bus.W_DataOut, wHeldVal);
      end
      if (iHeld) begin
        check("iStallValid", 32'(bus.I_DataOutValid), 32'd1);
        check("iStallData", bus.I_DataOut, iHeldVal);
      end
      wHeld    = bus.W_DataOutValid && !bus.W_DataOutRdy;
      wHeldVal = bus.W_DataOut;
      iHeld    = bus.I_DataOutValid && !bus.I_DataOutRdy;
      iHeldVal = bus.I_DataOut;
      if (bus.W_DataOutValid && bus.W_DataOutRdy) wObs.push_back(bus.W_DataOut);
      if (bus.I_DataOutValid && bus.I_DataOutRdy) begin
        iObs.push_back(bus.I_DataOut);
        lastIHsCyc = cyc;
      end
      if (bus.O_DataOutValid && bus.O_DataOutRdy) oObs.push_back(bus.O_DataOut);
      if (bus.I_RdEn) iAddrObs.push_back(bus.I_RdAddr);
      if (firstValidCyc < 0 && bus.W_DataOutValid) firstValidCyc = cyc;
      if (bus.Done) begin
        doneCnt++;
        doneCyc = cyc;
      end
      if (bus.Busy) busyCyc++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clearObs();
    wObs.delete(); iObs.delete(); oObs.delete(); iAddrObs.delete();
    doneCnt = 0; busyCyc = 0; firstValidCyc = -1; lastIHsCyc = -1; doneCyc = -1;
  endtask

  task automatic loadMem(input int wb, input int ib, input int ob);
    for (int a = 0; a < 1024; a++) begin
      wMem[a] = 32'hBAD0_0000 | 32'(a);
      iMem[a] = 32'hBAD1_0000 | 32'(a);
      oMem[a] = 32'hBAD2_0000 | 32'(a);
    end
    for (int j = 0; j < 4; j++)  wMem[(wb + j) % 1024] = f2b(5 * (j + 1));
    for (int j = 0; j < 19; j++) iMem[(ib + j) % 1024] = f2b(j + 1);
    for (int j = 0; j < 4; j++)  oMem[(ob + j) % 1024] = f2b(10 * (j + 1));
    bus.W_Base = AW'(wb);
    bus.I_Base = AW'(ib);
    bus.O_Base = AW'(ob);
  endtask

  // mode 0: all Rdy high; 1: I Rdy toggles, W Rdy low for 5 cycles in
  // block 1; 2: second Start pulse at cycle 3.
  task automatic runTile(input int mode, input int expDone);
    int rel;
    rel = 0;
    startCyc = cyc;
    bus.Start = 1'b1;
    while (doneCnt < expDone && rel < 200) begin
      @(posedge clk); #1;
      rel++;
      bus.Start = (mode == 2 && rel == 3);
      if (mode == 1) begin
        bus.I_DataOutRdy = ~bus.I_DataOutRdy;
        bus.W_DataOutRdy = !(rel >= 7 && rel <= 11);
      end
    end
    check("tileTimeout", 32'(rel < 200), 32'd1);
    bus.W_DataOutRdy = 1'b1;
    bus.I_DataOutRdy = 1'b1;
    bus.O_DataOutRdy = 1'b1;
  endtask

  task automatic checkStreams(input string tag, input int nTiles);
    check({tag, " wCount"}, 32'(wObs.size()), 32'(16 * nTiles));
    check({tag, " iCount"}, 32'(iObs.size()), 32'(19 * nTiles));
    check({tag, " oCount"}, 32'(oObs.size()), 32'(4 * nTiles));
    expQ.delete();
    for (int t = 0; t < nTiles; t++)
      for (int k = 0; k < 16; k++) expQ.push_back(f2b(5 * ((k % 4) + 1)));
    for (int k = 0; k < 16 * nTiles; k++)
      check($sformatf("%s w[%0d]", tag, k), (k < wObs.size()) ? wObs[k] : 'x, expQ.pop_front());
    for (int t = 0; t < nTiles; t++)
      for (int k = 0; k < 19; k++) expQ.push_back(f2b(k + 1));
    for (int k = 0; k < 19 * nTiles; k++)
      check($sformatf("%s i[%0d]", tag, k), (k < iObs.size()) ? iObs[k] : 'x, expQ.pop_front());
    for (int t = 0; t < nTiles; t++)
      for (int k = 0; k < 4; k++) expQ.push_back(f2b(10 * (k + 1)));
    for (int k = 0; k < 4 * nTiles; k++)
      check($sformatf("%s o[%0d]", tag, k), (k < oObs.size()) ? oObs[k] : 'x, expQ.pop_front());
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed hang, expected summary");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    aclr = 1'b1;
    bus.Start = 1'b0;
    bus.W_DataOutRdy = 1'b1;
    bus.I_DataOutRdy = 1'b1;
    bus.O_DataOutRdy = 1'b1;
    loadMem(100, 200, 300);
    clearObs();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rstBusy",   32'(bus.Busy), 32'd0);
    check("rstDone",   32'(bus.Done), 32'd0);
    check("rstWValid", 32'(bus.W_DataOutValid), 32'd0);
    check("rstIValid", 32'(bus.I_DataOutValid), 32'd0);
    check("rstOValid", 32'(bus.O_DataOutValid), 32'd0);
    check("rstRdEn",   32'({bus.W_RdEn, bus.I_RdEn, bus.O_RdEn}), 32'd0);
    check("rstWData",  bus.W_DataOut, 32'd0);
    check("rstState",  32'(stateDbg), 32'(IDLE));
    check("rstBlock",  32'(blockDbg), 32'd0);
    aclr = 1'b0;
    @(posedge clk); #1;

    // Nominal tile
    clearObs();
    runTile(0, 1);
    checkStreams("nominal", 1);
    check("nomDoneCnt",    32'(doneCnt), 32'd1);
    check("nomFirstValid", 32'(firstValidCyc - startCyc), 32'(RdLatency + 1));
    check("nomBusyCycles", 32'(busyCyc), 32'd21);
    check("nomDoneAfterI", 32'(doneCyc - lastIHsCyc), 32'd1);
    check("nomIdleBusy",   32'(bus.Busy), 32'd0);
    check("nomBlockWrap",  32'(blockDbg), 32'd0);
    check("nomIdleState",  32'(stateDbg), 32'(IDLE));

    // Backpressure
    @(posedge clk); #1;
    clearObs();
    runTile(1, 1);
    checkStreams("backpressure", 1);
    check("bpDoneCnt",    32'(doneCnt), 32'd1);
    check("bpDoneAfterI", 32'(doneCyc - lastIHsCyc), 32'd1);

    // Start while busy
    @(posedge clk); #1;
    clearObs();
    runTile(2, 1);
    repeat (5) @(posedge clk);
    #1;
    checkStreams("startBusy", 1);
    check("sbDoneCnt",    32'(doneCnt), 32'd1);
    check("sbBusyCycles", 32'(busyCyc), 32'd21);

    // Reset mid-tile
    clearObs();
    bus.Start = 1'b1;
    for (int r = 1; r <= 8; r++) begin
      @(posedge clk); #1;
      bus.Start = 1'b0;
    end
    aclr = 1'b1;
    @(posedge clk); #1;
    aclr = 1'b0;
    check("midRstBusy",   32'(bus.Busy), 32'd0);
    check("midRstValids", 32'({bus.W_DataOutValid, bus.I_DataOutValid, bus.O_DataOutValid}), 32'd0);
    check("midRstState",  32'(stateDbg), 32'(IDLE));
    repeat (25) @(posedge clk);
    #1;
    check("midRstNoDone", 32'(doneCnt), 32'd0);
    check("midRstIdle",   32'(bus.Busy), 32'd0);
    clearObs();
    runTile(0, 1);
    checkStreams("afterReset", 1);
    check("arDoneCnt", 32'(doneCnt), 32'd1);

    // Address wrap on the I channel
    @(posedge clk); #1;
    loadMem(100, 1021, 300);
    clearObs();
    runTile(0, 1);
    checkStreams("wrap", 1);
    check("wrapAddrCount", 32'(iAddrObs.size()), 32'd19);
    check("wrapAddr0", 32'(iAddrObs[0]), 32'd1021);
    check("wrapAddr1", 32'(iAddrObs[1]), 32'd1022);
    check("wrapAddr2", 32'(iAddrObs[2]), 32'd1023);
    check("wrapAddr3", 32'(iAddrObs[3]), 32'd0);
    check("wrapAddr4", 32'(iAddrObs[4]), 32'd1);

    // Back-to-back tiles: second Start in the cycle after Done
    loadMem(100, 200, 300);
    clearObs();
    runTile(0, 1);
    runTile(0, 2);
    checkStreams("backToBack", 2);
    check("b2bDoneCnt", 32'(doneCnt), 32'd2);
    check("b2bIdle",    32'(bus.Busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
